vtg_programmable: RTL and testbench

- Parametrised, run-time-programmable video timing generator; successor to the fixed-mode timing table plus counter pair in the pattern path.
- Produces hs/vs/de, active-pixel coordinates and frame markers from a timing set loaded over a valid/ready-style config port.
- New timing is double-buffered and takes effect only at a frame boundary, so mode changes never emit a truncated line or frame.
- Sits in the pixel-clock domain between the PLL output and the pattern/sprite renderer.

---
 rtl/vtg_programmable.sv | 193 +++++++++++++++++++
 tb/tb_vtg_programmable.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtg_programmable.sv
// rtl/vtg_programmable.sv - run-time programmable video timing generator
module vtg_programmable #(
    parameter int   CNT_W       = 12,
    parameter int   FRM_W       = 8,
    parameter int   DEF_H_TOTAL = 799,
    parameter int   DEF_H_SYNC  = 95,
    parameter int   DEF_H_START = 143,
    parameter int   DEF_H_END   = 783,
    parameter int   DEF_V_TOTAL = 524,
    parameter int   DEF_V_SYNC  = 1,
    parameter int   DEF_V_START = 34,
    parameter int   DEF_V_END   = 514,
    parameter logic DEF_HS_POL  = 1'b0,
    parameter logic DEF_VS_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_h_total,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_start,
    input  logic [CNT_W-1:0] cfg_h_end,
    input  logic [CNT_W-1:0] cfg_v_total,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_start,
    input  logic [CNT_W-1:0] cfg_v_end,
    input  logic             cfg_hs_pol,
    input  logic             cfg_vs_pol,
    output logic             cfg_applied,
    output logic             cfg_err,
    output logic             vid_hs,
    output logic             vid_vs,
    output logic             vid_de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             sof,
    output logic             sol,
    output logic [FRM_W-1:0] frame_cnt
);

    typedef struct packed {
        logic [CNT_W-1:0] h_total;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_start;
        logic [CNT_W-1:0] h_end;
        logic [CNT_W-1:0] v_total;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_start;
        logic [CNT_W-1:0] v_end;
        logic             hs_pol;
        logic             vs_pol;
    } timing_t;

    localparam timing_t DEF_SET = '{
        h_total: CNT_W'(DEF_H_TOTAL),
        h_sync:  CNT_W'(DEF_H_SYNC),
        h_start: CNT_W'(DEF_H_START),
        h_end:   CNT_W'(DEF_H_END),
        v_total: CNT_W'(DEF_V_TOTAL),
        v_sync:  CNT_W'(DEF_V_SYNC),
        v_start: CNT_W'(DEF_V_START),
        v_end:   CNT_W'(DEF_V_END),
        hs_pol:  DEF_HS_POL,
        vs_pol:  DEF_VS_POL
    };

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

    timing_t          act_set;
    timing_t          shadow_set;
    timing_t          cfg_word;
    logic             pending;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic             cfg_ok;
    logic             frame_end;
    logic             do_apply;
    logic             hs_int;
    logic             vs_int;
    logic             h_act;
    logic             v_act;
    logic             de_int;
    logic [CNT_W-1:0] x_int;
    logic [CNT_W-1:0] y_int;

    assign cfg_word = '{
        h_total: cfg_h_total, h_sync: cfg_h_sync, h_start: cfg_h_start, h_end: cfg_h_end,
        v_total: cfg_v_total, v_sync: cfg_v_sync, v_start: cfg_v_start, v_end: cfg_v_end,
        hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol
    };

    // A word is only usable if sync, porch and active regions are strictly ordered inside the total
    assign cfg_ok = (cfg_word.h_sync < cfg_word.h_start) && (cfg_word.h_start < cfg_word.h_end) &&
                    (cfg_word.h_end <= cfg_word.h_total) &&
                    (cfg_word.v_sync < cfg_word.v_start) && (cfg_word.v_start < cfg_word.v_end) &&
                    (cfg_word.v_end <= cfg_word.v_total);

    assign frame_end = run && (h_cnt == act_set.h_total) && (v_cnt == act_set.v_total);
    // While stopped the counters sit at (0,0), so a pending word can be taken without tearing a frame
    assign do_apply  = pending && (frame_end || !run);
    assign cfg_ready = !pending;

    assign hs_int = h_cnt <= act_set.h_sync;
    assign vs_int = v_cnt <= act_set.v_sync;
    assign h_act  = (h_cnt > act_set.h_start) && (h_cnt <= act_set.h_end);
    assign v_act  = (v_cnt > act_set.v_start) && (v_cnt <= act_set.v_end);
    assign de_int = h_act && v_act;
    assign x_int  = h_cnt - act_set.h_start - CNT_ONE;
    assign y_int  = v_cnt - act_set.v_start - CNT_ONE;

    // Config capture into the shadow set and frame-boundary transfer to the active set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_set     <= DEF_SET;
            shadow_set  <= DEF_SET;
            pending     <= 1'b0;
            cfg_applied <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_applied <= do_apply;
            cfg_err     <= cfg_valid && !cfg_ok;
            if (do_apply) begin
                act_set <= shadow_set;
            end
            // A fresh word arriving on the apply cycle lands in the shadow after the old one was taken
            if (cfg_valid && cfg_ok) begin
                shadow_set <= cfg_word;
                pending    <= 1'b1;
            end else if (do_apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Horizontal/vertical position counters, parked at the origin while stopped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == act_set.h_total) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == act_set.v_total) ? '0 : v_cnt + CNT_ONE;
        end else begin
            h_cnt <= h_cnt + CNT_ONE;
        end
    end

    // Registered decode of the current counter position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_hs <= !DEF_HS_POL;
            vid_vs <= !DEF_VS_POL;
            vid_de <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
            sol    <= 1'b0;
            sof    <= 1'b0;
        end else if (!run) begin
            vid_hs <= !act_set.hs_pol;
            vid_vs <= !act_set.vs_pol;
            vid_de <= 1'b0;
            pix_x  <= '0;
            pix_y  <= '0;
            sol    <= 1'b0;
            sof    <= 1'b0;
        end else begin
            vid_hs <= act_set.hs_pol ? hs_int : !hs_int;
            vid_vs <= act_set.vs_pol ? vs_int : !vs_int;
            vid_de <= de_int;
            pix_x  <= de_int ? x_int : '0;
            pix_y  <= de_int ? y_int : '0;
            sol    <= de_int && (x_int == '0);
            sof    <= de_int && (x_int == '0) && (y_int == '0);
        end
    end

    // Completed-frame counter, free-running modulo 2^FRM_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + FRM_ONE;
        end
    end

endmodule

// File: tb/tb_vtg_programmable.sv
// tb/tb_vtg_programmable.sv - randomized bench for vtg_programmable against a frame-index model
`timescale 1ns/1ps
module tb_vtg_programmable;

    localparam int CW = 12;

    typedef struct {
        int ht, hs, hst, he, vt, vs, vst, ve;
        bit hp, vp;
    } tim_t;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic run       = 1'b0;
    logic cfg_valid = 1'b0;
    tim_t cw;

    logic          cfg_ready, cfg_applied, cfg_err;
    logic          vid_hs, vid_vs, vid_de, sof, sol;
    logic [CW-1:0] pix_x, pix_y;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    vtg_programmable dut (
        .clk(clk), .reset(rst), .run(run), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_total(CW'(cw.ht)), .cfg_h_sync(CW'(cw.hs)), .cfg_h_start(CW'(cw.hst)), .cfg_h_end(CW'(cw.he)),
        .cfg_v_total(CW'(cw.vt)), .cfg_v_sync(CW'(cw.vs)), .cfg_v_start(CW'(cw.vst)), .cfg_v_end(CW'(cw.ve)),
        .cfg_hs_pol(cw.hp), .cfg_vs_pol(cw.vp), .cfg_applied(cfg_applied), .cfg_err(cfg_err),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .pix_x(pix_x), .pix_y(pix_y),
        .sof(sof), .sol(sol), .frame_cnt(frame_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: position is a linear index into the frame
    tim_t act, sh, DEF;
    bit   pend;
    int   m_idx;
    bit   e_hs, e_vs, e_de, e_sof, e_sol, e_ready, e_applied, e_err;
    int   e_x, e_y, e_fc;

    logic [39:0] obs_bus, exp_bus;
    assign obs_bus = {vid_hs, vid_vs, vid_de, pix_x, pix_y, sof, sol, frame_cnt, cfg_ready, cfg_applied, cfg_err};
    always_comb exp_bus = {e_hs, e_vs, e_de, CW'(e_x), CW'(e_y), e_sof, e_sol, 8'(e_fc), e_ready, e_applied, e_err};

    int          cyc = 0;
    int          lk_bad, lk_cyc;
    logic [39:0] lk_got, lk_exp;

    function automatic tim_t mk(input int ht, hs, hst, he, vt, vs, vst, ve, input bit hp, vp);
        tim_t t;
        t.ht = ht; t.hs = hs; t.hst = hst; t.he = he;
        t.vt = vt; t.vs = vs; t.vst = vst; t.ve = ve;
        t.hp = hp; t.vp = vp;
        return t;
    endfunction

    function automatic bit tim_ok(input tim_t t);
        return (t.hs < t.hst) && (t.hst < t.he) && (t.he <= t.ht) &&
               (t.vs < t.vst) && (t.vst < t.ve) && (t.ve <= t.vt);
    endfunction

    function automatic int flen(input tim_t t);
        return (t.ht + 1) * (t.vt + 1);
    endfunction

    function automatic tim_t rnd_tim();
        tim_t t;
        t.hs  = int'($urandom_range(0, 3));
        t.hst = t.hs + int'($urandom_range(1, 3));
        t.he  = t.hst + int'($urandom_range(1, 4));
        t.ht  = t.he + int'($urandom_range(0, 3));
        t.vs  = int'($urandom_range(0, 2));
        t.vst = t.vs + int'($urandom_range(1, 2));
        t.ve  = t.vst + int'($urandom_range(1, 4));
        t.vt  = t.ve + int'($urandom_range(0, 2));
        t.hp  = 1'($urandom_range(0, 1));
        t.vp  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) t.he = t.hst;
        return t;
    endfunction

    task automatic model_reset();
        act = DEF; sh = DEF; pend = 1'b0; m_idx = 0;
        e_hs = !DEF.hp; e_vs = !DEF.vp; e_de = 0; e_x = 0; e_y = 0;
        e_sof = 0; e_sol = 0; e_fc = 0; e_ready = 1; e_applied = 0; e_err = 0;
    endtask

    task automatic model_step();
        int hl, fl, h, v;
        bit fe, de, ok, acc, ap;
        hl = act.ht + 1;
        fl = hl * (act.vt + 1);
        h  = m_idx % hl;
        v  = m_idx / hl;
        fe = run && (m_idx == fl - 1);
        de = (h > act.hst) && (h <= act.he) && (v > act.vst) && (v <= act.ve);
        if (run) begin
            e_hs  = (h <= act.hs) == act.hp;
            e_vs  = (v <= act.vs) == act.vp;
            e_de  = de;
            e_x   = de ? h - act.hst - 1 : 0;
            e_y   = de ? v - act.vst - 1 : 0;
            e_sol = de && (e_x == 0);
            e_sof = e_sol && (e_y == 0);
        end else begin
            e_hs = !act.hp; e_vs = !act.vp; e_de = 0; e_x = 0; e_y = 0; e_sol = 0; e_sof = 0;
        end
        ok  = tim_ok(cw);
        acc = cfg_valid && ok;
        ap  = pend && (fe || !run);
        e_err     = cfg_valid && !ok;
        e_applied = ap;
        if (fe) e_fc = (e_fc + 1) % 256;
        m_idx = (!run || fe) ? 0 : m_idx + 1;
        if (ap) act = sh;
        if (acc) sh = cw;
        pend    = acc || (pend && !ap);
        e_ready = !pend;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (obs_bus !== exp_bus) begin
            if (lk_bad == 0) begin
                lk_cyc = cyc; lk_got = obs_bus; lk_exp = exp_bus;
            end
            lk_bad++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        #1;
        n_tests++;
        if (obs_bus !== exp_bus) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", obs_bus, exp_bus);
        end
        rst = 1'b0;
    endtask

    task automatic test_default();
        int first_de = -1, hs_low = 0, de_line = 0;
        logic [CW-1:0] fx = '1, fy = '1;
        logic fsof = 1'b0;
        lk_bad = 0;
        run = 1'b1;
        for (int t = 1; t <= 28960; t++) begin
            tick();
            if (t <= 800 && !vid_hs) hs_low++;
            if (vid_de && first_de < 0) begin
                first_de = t; fx = pix_x; fy = pix_y; fsof = sof;
            end
            if (first_de > 0 && t < first_de + 800 && vid_de) de_line++;
        end
        n_tests++;
        if (first_de != (DEF.vst + 1) * (DEF.ht + 1) + DEF.hst + 2) begin
            n_fail++; $display("FAIL default_first_de: got %0d want %0d", first_de, (DEF.vst + 1) * (DEF.ht + 1) + DEF.hst + 2);
        end
        n_tests++;
        if (fx !== 0 || fy !== 0 || fsof !== 1'b1) begin
            n_fail++; $display("FAIL default_first_pixel: got x=%0d y=%0d sof=%b want 0 0 1", fx, fy, fsof);
        end
        n_tests++;
        if (hs_low != 96) begin
            n_fail++; $display("FAIL default_hs_width: got %0d want 96", hs_low);
        end
        n_tests++;
        if (de_line != 640) begin
            n_fail++; $display("FAIL default_line_width: got %0d want 640", de_line);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL default_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_invalid();
        int errs = 0, busy = 0;
        lk_bad = 0;
        cw = mk(9, 1, 8, 7, 5, 0, 1, 4, 1, 1);
        cfg_valid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            cfg_valid = 1'b0;
            if (cfg_err) errs++;
            if (!cfg_ready) busy++;
        end
        n_tests++;
        if (errs != 1) begin
            n_fail++; $display("FAIL invalid_err_pulse: got %0d pulses want 1", errs);
        end
        n_tests++;
        if (busy != 0) begin
            n_fail++; $display("FAIL invalid_ready: got %0d busy cycles want 0", busy);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL invalid_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_small_apply();
        int ready_hi = 0, applied = 0, period = -1, des = 0, hs_hi = 0, maxx = 0, maxy = 0;
        bit found = 0;
        lk_bad = 0;
        cw = mk(9, 1, 3, 7, 5, 0, 1, 4, 1, 1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        n_tests++;
        if (cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL small_pending_ready: got %b want 0", cfg_ready);
        end
        for (int t = 0; t < 20; t++) begin
            tick();
            if (cfg_ready) ready_hi++;
        end
        n_tests++;
        if (ready_hi != 0) begin
            n_fail++; $display("FAIL small_ready_held: got %0d ready cycles want 0", ready_hi);
        end
        run = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (cfg_applied) applied++;
        end
        n_tests++;
        if (applied != 1) begin
            n_fail++; $display("FAIL small_applied_stopped: got %0d pulses want 1", applied);
        end
        run = 1'b1;
        for (int t = 0; t < 300 && !found; t++) begin
            tick();
            found = sof;
        end
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (vid_de) des++;
            if (vid_hs) hs_hi++;
            if (int'(pix_x) > maxx) maxx = int'(pix_x);
            if (int'(pix_y) > maxy) maxy = int'(pix_y);
            if (sof && period < 0) period = t;
        end
        n_tests++;
        if (period != 60) begin
            n_fail++; $display("FAIL small_period: got %0d want 60", period);
        end
        n_tests++;
        if (des != 12 || maxx != 3 || maxy != 2) begin
            n_fail++; $display("FAIL small_area: got de=%0d maxx=%0d maxy=%0d want 12 3 2", des, maxx, maxy);
        end
        n_tests++;
        if (hs_hi != 12) begin
            n_fail++; $display("FAIL small_hs_width: got %0d want 12", hs_hi);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL small_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_two_writes();
        int ready_hi = 0, period = -1, delta = -1;
        bit found = 0, at_end = 0;
        lk_bad = 0;
        cw = mk(11, 1, 3, 9, 5, 0, 1, 4, 1, 1);
        cfg_valid = 1'b1;
        tick();
        cw = mk(9, 2, 4, 8, 6, 1, 2, 5, 0, 1);
        tick();
        cfg_valid = 1'b0;
        for (int t = 0; t < 300 && !found; t++) begin
            tick();
            found = cfg_applied;
            if (!found && cfg_ready) ready_hi++;
        end
        n_tests++;
        if (!found || ready_hi != 0) begin
            n_fail++; $display("FAIL two_pending: applied=%b ready_cycles=%0d want 1 0", found, ready_hi);
        end
        found = 0;
        for (int t = 0; t < 300 && !found; t++) begin
            tick();
            found = sof;
        end
        for (int t = 1; t <= 100 && period < 0; t++) begin
            tick();
            if (sof) period = t;
        end
        n_tests++;
        if (period != 70) begin
            n_fail++; $display("FAIL two_second_wins_period: got %0d want 70", period);
        end
        for (int t = 0; t < 200 && !at_end; t++) begin
            if (m_idx == flen(act) - 1) at_end = 1;
            else tick();
        end
        cw = mk(9, 1, 3, 7, 5, 0, 1, 4, 1, 1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int t = 1; t <= 200 && delta < 0; t++) begin
            tick();
            if (cfg_applied) delta = t;
        end
        n_tests++;
        if (delta != 70) begin
            n_fail++; $display("FAIL frame_end_write_delay: got %0d want 70", delta);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL two_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_run_drop();
        int inact_bad = 0, fc_before;
        bit ok_pos = 0;
        logic [2:0] hs_seq;
        lk_bad = 0;
        for (int t = 0; t < 200 && !ok_pos; t++) begin
            if (m_idx >= 10 && m_idx % 10 == 5) ok_pos = 1;
            else tick();
        end
        fc_before = e_fc;
        run = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (vid_de || pix_x != 0 || pix_y != 0 || sol || sof || vid_hs !== 1'b0 || vid_vs !== 1'b0) inact_bad++;
        end
        n_tests++;
        if (!ok_pos || inact_bad != 0) begin
            n_fail++; $display("FAIL run_drop_inactive: aligned=%b bad=%0d want 1 0", ok_pos, inact_bad);
        end
        run = 1'b1;
        tick(); hs_seq[2] = vid_hs;
        n_tests++;
        if (int'(frame_cnt) != fc_before) begin
            n_fail++; $display("FAIL run_drop_frame_cnt: got %0d want %0d", frame_cnt, fc_before);
        end
        tick(); hs_seq[1] = vid_hs;
        tick(); hs_seq[0] = vid_hs;
        n_tests++;
        if (hs_seq !== 3'b110) begin
            n_fail++; $display("FAIL run_restart_hs: got %b want 110", hs_seq);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL run_drop_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] prev;
        bit wrapped = 0;
        lk_bad = 0;
        prev = frame_cnt;
        for (int t = 0; t < 300 * 60 && !wrapped; t++) begin
            tick();
            if (prev == 8'd255 && frame_cnt == 8'd0) wrapped = 1;
            prev = frame_cnt;
        end
        n_tests++;
        if (!wrapped) begin
            n_fail++; $display("FAIL frame_cnt_wrap: got no 255->0 transition want one");
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL wrap_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_random();
        lk_bad = 0;
        for (int t = 0; t < 6000; t++) begin
            if ($urandom_range(0, 63) == 0) run = !run;
            if ($urandom_range(0, 39) == 0) begin
                cw = rnd_tim();
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end
        cfg_valid = 1'b0;
        run = 1'b1;
        tick();
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL random_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    task automatic test_async_reset();
        int hs_low = 0, busy = 0;
        lk_bad = 0;
        cw = mk(9, 1, 3, 7, 5, 0, 1, 4, 1, 1);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (obs_bus !== exp_bus) begin
            n_fail++; $display("FAIL async_reset_values: got %h want %h", obs_bus, exp_bus);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 1; t <= 900; t++) begin
            tick();
            if (t <= 800 && !vid_hs) hs_low++;
            if (!cfg_ready) busy++;
        end
        n_tests++;
        if (hs_low != 96 || busy != 0) begin
            n_fail++; $display("FAIL async_reset_default_timing: hs_low=%0d busy=%0d want 96 0", hs_low, busy);
        end
        n_tests++;
        if (lk_bad !== 0) begin
            n_fail++; $display("FAIL async_lockstep: %0d bad cycles want 0, first cyc %0d got %h want %h", lk_bad, lk_cyc, lk_got, lk_exp);
        end
    endtask

    initial begin
        DEF = mk(799, 95, 143, 783, 524, 1, 34, 514, 1'b0, 1'b0);
        cw  = DEF;
        test_reset();
        test_default();
        test_invalid();
        test_small_apply();
        test_two_writes();
        test_run_drop();
        test_frame_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
